valve_chain_sequencer: RTL and testbench
========================================

VALVE_CHAIN_SEQUENCER -- requirements
Module: valve_chain_sequencer

Interface
REQ-001 SHALL have parameter NUM_VALVES, default 4: number of valves in the driven chain, with a minimum of 2.
REQ-002 SHALL have parameter STEP_W, default 16: width of the phase-period field.
REQ-003 SHALL have parameter CNT_W, default 8: width of the cycle-count field.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: request to begin a pumping run; sampled in IDLE only.
REQ-007 SHALL have port stop, input, 1 bit: abort request; honoured in any state.
REQ-008 SHALL have port dir, input, 1 bit: 0 = forward (valve 0 to N-1), 1 = reverse; latched at start.
REQ-009 SHALL have port step_period, input, STEP_W bits: phase length in clocks; latched at start.
REQ-010 SHALL have port num_cycles, input, CNT_W bits: number of full pump cycles; 0 = run until stop; latched at start.
REQ-011 SHALL have port valve_ctrl, output, NUM_VALVES bits: per-valve in_air drive; 1 = pressurised/closed, 0 = vented/open.
REQ-012 SHALL have port busy, output, 1 bit: high while a run is active.
REQ-013 SHALL have port done, output, 1 bit: one-clock pulse on normal run completion.
REQ-014 SHALL have port step_strobe, output, 1 bit: one-clock pulse on the first clock of every phase.

Function
REQ-015 FSM states SHALL be IDLE, RUN and FINISH.
REQ-016 In IDLE, start=1 with stop=0 SHALL latch dir/step_period/num_cycles and enter RUN; busy=1 from the next clock.
REQ-017 Effective period SHALL be max(step_period,1); each phase SHALL last exactly that many clocks.
REQ-018 In phase k exactly one valve SHALL be open: valve k when forward, valve NUM_VALVES-1-k when reverse; all other bits 1.
REQ-019 The first phase SHALL appear on valve_ctrl on the clock after start is accepted, together with step_strobe=1.
REQ-020 One cycle SHALL equal NUM_VALVES phases; the phase index SHALL wrap from NUM_VALVES-1 to 0.
REQ-021 After the last phase of cycle num_cycles (num_cycles>0), the FSM SHALL enter FINISH for one clock: valve_ctrl all ones, done=1, busy=0; then enter IDLE.
REQ-022 With num_cycles=0, the run SHALL continue indefinitely; the internal cycle counter SHALL saturate, not wrap.
REQ-023 stop=1 in RUN SHALL force valve_ctrl all ones and busy=0 on the next clock, enter IDLE, and never assert done.
REQ-024 start and stop high in the same IDLE clock: stop SHALL win and no run SHALL start.
REQ-025 start while busy SHALL be ignored; input changes during a run SHALL have no effect.
REQ-026 stop in the same clock as the final phase end SHALL take priority and suppress done.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, valve_ctrl all ones, and busy/done/step_strobe=0, including in the middle of a run.
REQ-028 The first start after rst_n deasserts SHALL be accepted on its first sampled clock.

Configuration
REQ-029 Macro VALVE_SEQ_OVERLAP_EN, when defined, SHALL open the next valve in sequence during the last clock of each phase, except the final phase of a finite run, whenever the effective period is 2 or more.
REQ-030 Without VALVE_SEQ_OVERLAP_EN, valve_ctrl SHALL never have more than one bit at 0.

Structure
REQ-031 Package valve_seq_pkg SHALL hold the FSM state enum and the constant VALVE_CLOSED = 1'b1.
REQ-032 Sub-module valve_seq_timer SHALL hold the loadable phase down-counter and generate the phase-end pulse; all other logic stays in the top module.

Verification
REQ-033 Forward run: step_period=3, num_cycles=1 -> valve_ctrl = 1110, 1101, 1011, 0111, 3 clocks each (bit 0 rightmost); then all ones with done pulse; 12 RUN clocks in total.
REQ-034 Reverse run: dir=1, step_period=0 -> valve_ctrl = 0111, 1011, 1101, 1110 on consecutive clocks; step_strobe high every clock.
REQ-035 Abort: num_cycles=0, stop asserted on RUN clock 7 -> all ones and busy=0 next clock; no done; a new start is then accepted.
REQ-036 Reset mid-run: rst_n low during phase 2 -> same-cycle valve_ctrl all ones and busy=0; start accepted after release.
REQ-037 Overlap build (VALVE_SEQ_OVERLAP_EN), step_period=2, forward -> 1110 then 1100 in phase 0; final clock of the run 0111, not overlapped.
REQ-038 Simultaneous start and stop in IDLE -> no busy, valve_ctrl unchanged; start while busy -> run length unchanged.

Source files
------------

// File: rtl/valve_seq_pkg.sv
// Shared types and constants for the valve chain sequencer.
package valve_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic VALVE_CLOSED = 1'b1;

endpackage

// File: rtl/valve_seq_timer.sv
// Loadable phase down-counter; end_o marks the last clock of a phase.
module valve_seq_timer #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [STEP_W-1:0] load_val_i,
  output logic [STEP_W-1:0] cnt_o,
  output logic              end_o
);

  logic [STEP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - STEP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign end_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/valve_chain_sequencer.sv
// Peristaltic valve chain sequencer: one open valve walks the chain per phase.
// Optional macro VALVE_SEQ_OVERLAP_EN opens the next valve on a phase's last clock.
module valve_chain_sequencer
  import valve_seq_pkg::*;
#(
  parameter int NUM_VALVES = 4,
  parameter int STEP_W     = 16,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir,
  input  logic [STEP_W-1:0]     step_period,
  input  logic [CNT_W-1:0]      num_cycles,
  output logic [NUM_VALVES-1:0] valve_ctrl,
  output logic                  busy,
  output logic                  done,
  output logic                  step_strobe
);

  localparam int PH_W = $clog2(NUM_VALVES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NUM_VALVES - 1);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] per_q, per_d;    // effective period minus one
  logic [CNT_W-1:0]  ncyc_q, ncyc_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;    // completed cycles, saturating
  logic [PH_W-1:0]   ph_q, ph_d;

  logic              in_run, accept, last_ph, last_cyc;
  logic [STEP_W-1:0] start_per_m1;
  logic              t_load, t_end;
  logic [STEP_W-1:0] t_load_val, t_cnt;
  logic [PH_W-1:0]   open_idx;

  assign in_run       = (state_q == RUN);
  assign accept       = (state_q == IDLE) && start && !stop;
  assign last_ph      = (ph_q == PH_LAST);
  assign last_cyc     = (ncyc_q != '0) && (cyc_q == ncyc_q - CNT_W'(1));
  assign start_per_m1 = (step_period == '0) ? '0 : step_period - STEP_W'(1);

  assign t_load     = accept || t_end;
  assign t_load_val = accept ? start_per_m1 : per_q;

  valve_seq_timer #(.STEP_W(STEP_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (t_load),
    .en_i       (in_run),
    .load_val_i (t_load_val),
    .cnt_o      (t_cnt),
    .end_o      (t_end)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    per_d   = per_q;
    ncyc_d  = ncyc_q;
    cyc_d   = cyc_q;
    ph_d    = ph_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        dir_d   = dir;
        per_d   = start_per_m1;
        ncyc_d  = num_cycles;
        cyc_d   = '0;
        ph_d    = '0;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (t_end) begin
          if (last_ph) begin
            ph_d = '0;
            if (last_cyc)       state_d = FINISH;
            else if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      per_q   <= '0;
      ncyc_q  <= '0;
      cyc_q   <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      per_q   <= per_d;
      ncyc_q  <= ncyc_d;
      cyc_q   <= cyc_d;
      ph_q    <= ph_d;
    end
  end

  assign open_idx = dir_q ? (PH_LAST - ph_q) : ph_q;

`ifdef VALVE_SEQ_OVERLAP_EN
  logic [PH_W-1:0] nxt_ph, nxt_idx;
  logic            ovl;
  assign nxt_ph  = last_ph ? '0 : ph_q + PH_W'(1);
  assign nxt_idx = dir_q ? (PH_LAST - nxt_ph) : nxt_ph;
  // No overlap when the run is about to finish or phases are one clock long.
  assign ovl     = in_run && (t_cnt == '0) && (per_q != '0) && !(last_ph && last_cyc);
`endif

  always_comb begin
    valve_ctrl = {NUM_VALVES{VALVE_CLOSED}};
    if (in_run) begin
      valve_ctrl[open_idx] = ~VALVE_CLOSED;
`ifdef VALVE_SEQ_OVERLAP_EN
      if (ovl) valve_ctrl[nxt_idx] = ~VALVE_CLOSED;
`endif
    end
  end

  assign busy        = in_run;
  assign done        = (state_q == FINISH);
  assign step_strobe = in_run && (t_cnt == per_q);

endmodule

// File: tb/tb_valve_chain_sequencer.sv
// Scoreboard bench: expected per-clock outputs queued at start, compared each clock.
module tb_valve_chain_sequencer;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          dir = 1'b0;
  logic [SW-1:0] step_period = '0;
  logic [CW-1:0] num_cycles = '0;
  logic [N-1:0]  valve_ctrl;
  logic          busy, done, step_strobe;

  always #5 clk = ~clk;

  valve_chain_sequencer #(.NUM_VALVES(N), .STEP_W(SW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .dir         (dir),
    .step_period (step_period),
    .num_cycles  (num_cycles),
    .valve_ctrl  (valve_ctrl),
    .busy        (busy),
    .done        (done),
    .step_strobe (step_strobe)
  );

  typedef struct packed {
    logic [N-1:0] vc;
    logic         busy;
    logic         done;
    logic         stb;
  } exp_t;

  exp_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;

  function automatic exp_t idle_e();
    exp_t e;
    e.vc = '1; e.busy = 1'b0; e.done = 1'b0; e.stb = 1'b0;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.vc = valve_ctrl; o.busy = busy; o.done = done; o.stb = step_strobe;
    return o;
  endfunction

  // c>0: full run plus FINISH and one idle clock; c==0: nclk run clocks only.
  task automatic push_run(input logic d, input int p, input int c, input int nclk);
    int   pe, total, k, j, cy, vi;
    exp_t e;
    pe    = (p < 1) ? 1 : p;
    total = (c > 0) ? c * N * pe : nclk;
    for (int t = 0; t < total; t++) begin
      k  = (t / pe) % N;
      j  = t % pe;
      cy = t / (pe * N);
      e.vc = '1;
      vi = d ? N - 1 - k : k;
      e.vc[vi] = 1'b0;
`ifdef VALVE_SEQ_OVERLAP_EN
      if (pe >= 2 && j == pe - 1 && !(c > 0 && cy == c - 1 && k == N - 1)) begin
        vi = d ? N - 1 - ((k + 1) % N) : (k + 1) % N;
        e.vc[vi] = 1'b0;
      end
`endif
      e.busy = 1'b1; e.done = 1'b0; e.stb = (j == 0);
      sb.push_back(e);
    end
    if (c > 0) begin
      e = idle_e(); e.done = 1'b1;
      sb.push_back(e);
      sb.push_back(idle_e());
    end
  endtask

  task automatic do_start(input logic d, input int p, input int c);
    dir = d; step_period = SW'(p); num_cycles = CW'(c); start = 1'b1;
  endtask

  task automatic drain(input string name, input int stop_at, input int disturb_at, input int max_n);
    int   idx;
    exp_t e, o;
    idx = 0;
    while (sb.size() > 0 && (max_n < 0 || idx < max_n)) begin
      @(posedge clk); #1;
      if (idx == 0) start = 1'b0;
      if (idx == stop_at + 1) stop = 1'b0;
      if (idx == disturb_at + 1) start = 1'b0;
      e = sb.pop_front();
      o = observe();
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got vc=%b busy=%b done=%b stb=%b, want vc=%b busy=%b done=%b stb=%b",
                 name, idx, o.vc, o.busy, o.done, o.stb, e.vc, e.busy, e.done, e.stb);
      end
      if (idx == stop_at) stop = 1'b1;
      if (idx == disturb_at) begin
        start = 1'b1; dir = ~dir; step_period = SW'(7); num_cycles = CW'(9);
      end
      idx++;
    end
    sb.delete();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic check_now(input string name);
    exp_t o;
    o = observe();
    n_run++;
    if (o !== idle_e()) begin
      n_fail++;
      $display("FAIL %s: got vc=%b busy=%b done=%b stb=%b, want vc=1111 busy=0 done=0 stb=0",
               name, o.vc, o.busy, o.done, o.stb);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1 check_now("reset_state");
    @(posedge clk); #1 check_now("reset_hold");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    do_start(1'b0, 3, 1); push_run(1'b0, 3, 1, 0);
    drain("forward", -1, -1, -1);
  endtask

  task automatic test_reverse();
    do_start(1'b1, 0, 1); push_run(1'b1, 0, 1, 0);
    drain("reverse", -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    do_start(1'b0, 2, 2); push_run(1'b0, 2, 2, 0);
    drain("multi_ignore_start", -1, 3, -1);
    do_start(1'b1, 3, 1); push_run(1'b1, 3, 1, 0);
    drain("back_to_back", -1, -1, -1);
  endtask

  task automatic test_abort();
    do_start(1'b0, 1, 0); push_run(1'b0, 1, 0, 7);
    sb.push_back(idle_e()); sb.push_back(idle_e());
    drain("abort", 6, -1, -1);
    do_start(1'b1, 1, 1); push_run(1'b1, 1, 1, 0);
    drain("after_abort", -1, -1, -1);
  endtask

  task automatic test_stop_final();
    do_start(1'b0, 1, 1); push_run(1'b0, 1, 1, 0);
    sb[4].done = 1'b0;
    drain("stop_final", 3, -1, -1);
  endtask

  task automatic test_start_stop_same();
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check_now("start_stop_same");
    @(posedge clk); #1 check_now("start_stop_same_hold");
  endtask

  task automatic test_reset_midrun();
    do_start(1'b0, 2, 1); push_run(1'b0, 2, 1, 0);
    drain("pre_reset", -1, -1, 5);
    rst_n = 1'b0;
    #1 check_now("reset_midrun");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(1'b0, 0, 1); push_run(1'b0, 0, 1, 0);
    drain("after_reset", -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_back_to_back();
    test_abort();
    test_stop_final();
    test_start_stop_same();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
